// File: rtl/p_fxp_mac_gather.sv
// Purpose : gathers IN saturating fixed-point products (x*w >> frac) into one parallel vector for the accumulator tree.
// Latency : out_valid rises the cycle after the accept that completes a vector; the product path is one register stage.
// Backpr. : a presented vector is held stable until out_ready; in_ready=0 while presenting unless bypass is built in.
//
// Optional feature macro: P_FXP_MAC_GATHER_BYPASS_EN
//   defined   -> in PRESENT, in_ready follows out_ready; a pair accepted in the handoff
//                cycle starts the next vector (IN cycles per vector sustained).
//   undefined -> in_ready=0 in PRESENT (IN+1 cycles per vector sustained).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     pair handshake; in_x, in_w operands in CONF format
//   in_last               accepted pair closes the vector; remaining slots read as zero
//   out_valid/out_ready   vector handshake
//   out_vec               packed products, slot k at [k*PREC +: PREC]
//   out_ovf, out_rounded  sticky: any product saturated / dropped nonzero fraction bits

package p_fxp_mac_gather_pkg;
    typedef struct packed {
        int unsigned prec;
        int unsigned frac;
        logic        sign;
    } dconf_t;
endpackage

`ifndef DEF_DCONF_FXP
`define DEF_DCONF_FXP p_fxp_mac_gather_pkg::dconf_t'{prec: 32'd16, frac: 32'd8, sign: 1'b1}
`endif

module p_fxp_mac_gather
    import p_fxp_mac_gather_pkg::*;
#(
    parameter int     IN   = 8,
    parameter dconf_t CONF = `DEF_DCONF_FXP,
    parameter int     PREC = CONF.prec
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PREC-1:0]    in_x,
    input  logic [PREC-1:0]    in_w,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IN*PREC-1:0] out_vec,
    output logic               out_ovf,
    output logic               out_rounded
);

    localparam int FRAC = CONF.frac;
    localparam bit SIGN = CONF.sign;
    localparam int CW   = $clog2(IN);
    localparam int W2   = 2 * PREC;
    localparam logic [W2-1:0] FRAC_MASK = (W2'(1) << FRAC) - W2'(1);

    typedef enum logic {FILL, PRESENT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [PREC-1:0]  vec_q [IN];
    logic             ovf_q, rnd_q;
    logic             accept;
    logic             last_slot;

    // ---------------- product: extend, multiply, shift, saturate ----------------
    // Operands are extended to 2*PREC bits up front so a plain multiply gives the
    // exact product for both signed and unsigned formats.
    logic [W2-1:0]        ext_x, ext_w, prod_full, prod_shr;
    logic signed [W2-1:0] prod_s;
    logic [PREC-1:0]      prod_val;
    logic                 prod_ovf, prod_rnd;

    always_comb begin
        ext_x    = SIGN ? {{PREC{in_x[PREC-1]}}, in_x} : {{PREC{1'b0}}, in_x};
        ext_w    = SIGN ? {{PREC{in_w[PREC-1]}}, in_w} : {{PREC{1'b0}}, in_w};
        prod_full = ext_x * ext_w;
        prod_s    = prod_full;
        prod_rnd  = |(prod_full & FRAC_MASK);
        prod_val  = prod_full[PREC-1:0];
        prod_ovf  = 1'b0;
        if (SIGN) begin
            // arithmetic shift floors toward -inf; in range iff bits above the
            // result sign bit are all copies of it
            prod_shr = prod_s >>> FRAC;
            prod_ovf = !((&prod_shr[W2-1:PREC-1]) || (~|prod_shr[W2-1:PREC-1]));
            prod_val = prod_ovf ? (prod_shr[W2-1] ? {1'b1, {(PREC-1){1'b0}}}
                                                  : {1'b0, {(PREC-1){1'b1}}})
                                : prod_shr[PREC-1:0];
        end else begin
            prod_shr = prod_full >> FRAC;
            prod_ovf = |prod_shr[W2-1:PREC];
            prod_val = prod_ovf ? {PREC{1'b1}} : prod_shr[PREC-1:0];
        end
    end

    // ---------------- control FSM ----------------
    assign last_slot = (cnt == CW'(IN - 1)) || in_last;

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            FILL: begin
                accept = in_valid;
                if (accept && last_slot) state_nxt = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
`ifdef P_FXP_MAC_GATHER_BYPASS_EN
                in_ready = out_ready;
`else
                in_ready = 1'b0;
`endif
                accept = in_valid && in_ready;
                if (out_ready) begin
                    // a single-pair vector taken during handoff is complete at once
                    state_nxt = (accept && in_last) ? PRESENT : FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // ---------------- vector buffer, count and sticky flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
            rnd_q <= 1'b0;
            for (int k = 0; k < IN; k++) vec_q[k] <= '0;
        end else if (state == FILL) begin
            if (accept) begin
                vec_q[cnt] <= prod_val;
                ovf_q      <= ovf_q | prod_ovf;
                rnd_q      <= rnd_q | prod_rnd;
                if (last_slot) begin
                    for (int k = 0; k < IN; k++)
                        if (k > int'(cnt)) vec_q[k] <= '0;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end else if (out_ready) begin
            for (int k = 0; k < IN; k++) vec_q[k] <= '0;
            ovf_q <= 1'b0;
            rnd_q <= 1'b0;
            cnt   <= '0;
            if (accept) begin
                // handoff accept seeds slot 0 of the next vector, flags start fresh
                vec_q[0] <= prod_val;
                ovf_q    <= prod_ovf;
                rnd_q    <= prod_rnd;
                cnt      <= in_last ? CW'(0) : CW'(1);
            end
        end
    end

    always_comb begin
        out_vec = '0;
        for (int k = 0; k < IN; k++) out_vec[k*PREC +: PREC] = vec_q[k];
    end

    assign out_ovf     = ovf_q;
    assign out_rounded = rnd_q;

endmodule

// File: tb/tb_p_fxp_mac_gather.sv
module tb_p_fxp_mac_gather;

    localparam int IN   = 4;
    localparam int PREC = 16;
`ifdef P_FXP_MAC_GATHER_BYPASS_EN
    localparam int PERIOD = 4;
`else
    localparam int PERIOD = 5;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready, in_last;
    logic [PREC-1:0]   in_x, in_w;
    logic              out_valid, out_ready;
    logic [IN*PREC-1:0] out_vec;
    logic              out_ovf, out_rounded;

    int ncmp = 0;
    int nfail = 0;

    // model state: pairs accepted for the vector currently being built
    logic [15:0] mx [IN];
    logic [15:0] mw [IN];
    int          mn = 0;
    logic [63:0] exp_vec;
    logic        exp_o, exp_r;

    p_fxp_mac_gather #(.IN(IN)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_ovf(out_ovf), .out_rounded(out_rounded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Q8.8 signed product: exact integer product, floor-divide by 256, clamp.
    function automatic void ref_prod(input logic [15:0] x, input logic [15:0] w,
                                     output logic [15:0] p, output logic o, output logic r);
        longint full, q;
        full = longint'($signed(x)) * longint'($signed(w));
        q    = full >>> 8;
        r    = (full & 64'sd255) != 0;
        o    = 1'b0;
        if (q > 32767)       begin p = 16'h7FFF; o = 1'b1; end
        else if (q < -32768) begin p = 16'h8000; o = 1'b1; end
        else                 p = q[15:0];
    endfunction

    function automatic void ref_vec(output logic [63:0] v, output logic o, output logic r);
        logic [15:0] p;
        logic        po, pr;
        v = '0; o = 1'b0; r = 1'b0;
        for (int k = 0; k < mn; k++) begin
            ref_prod(mx[k], mw[k], p, po, pr);
            v[k*16 +: 16] = p;
            o |= po;
            r |= pr;
        end
    endfunction

    // drive one pair at a negedge; returns at the negedge after it was accepted
    task automatic send(input logic [15:0] x, input logic [15:0] w, input logic last);
        in_valid = 1'b1; in_x = x; in_w = w; in_last = last;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        chk("send_rdy", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        if (mn < IN) begin mx[mn] = x; mw[mn] = w; mn++; end
    endtask

    task automatic check_vec(input string tag);
        ref_vec(exp_vec, exp_o, exp_r);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_vec"}, out_vec, exp_vec);
        chk({tag, "_ovf"}, out_ovf, exp_o);
        chk({tag, "_rnd"}, out_rounded, exp_r);
        mn = 0;
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_ir"}, in_ready, 1);
        chk({tag, "_vec"}, out_vec, 0);
        chk({tag, "_ovf"}, out_ovf, 0);
        chk({tag, "_rnd"}, out_rounded, 0);
    endtask

    initial begin
        logic [15:0] sx [12];
        logic [15:0] sw [12];
        logic [15:0] rx, rw;
        int n, idx, nhs, cyc, last_hs;

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst");

        // four identical pairs: 1.0 * 2.0 = 2.0 in every slot
        for (int i = 0; i < 4; i++) send(16'h0100, 16'h0200, 1'b0);
        check_vec("basic");
        chk("basic_const", out_vec, {4{16'h0200}});
        pop("basic");

        // positive and negative saturation
        send(16'h7FFF, 16'h7FFF, 1'b0);
        send(16'h8000, 16'h7FFF, 1'b1);
        check_vec("sat");
        chk("sat_const", out_vec, 64'h0000_0000_8000_7FFF);
        chk("sat_ovf_const", out_ovf, 1);
        pop("sat");

        // tiny products: truncation to zero and floor to -1/256
        send(16'h0001, 16'h0001, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b1);
        check_vec("floor");
        chk("floor_const", out_vec, 64'h0000_0000_FFFF_0000);
        chk("floor_rnd_const", out_rounded, 1);
        pop("floor");

        // short vector; out_ready during FILL must be ignored; then hold 5 cycles
        send(16'h0180, 16'hFF40, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("fill_ignore_ready", out_valid, 0);
        send(16'h0321, 16'h00F7, 1'b1);
        check_vec("short");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_vec", out_vec, exp_vec);
            chk("hold_flags", {out_ovf, out_rounded}, {exp_o, exp_r});
            chk("hold_in_ready", in_ready, 0);
        end
        pop("short");

        // reset in mid-fill discards the partial vector and its flags
        send(16'h7FFF, 16'h7FFF, 1'b0);
        send(16'h0001, 16'h0001, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mn = 0;
        check_reset_state("midrst");
        send(16'h0100, 16'h0300, 1'b0);
        send(16'h0200, 16'h0080, 1'b0);
        send(16'hFF00, 16'h0100, 1'b0);
        send(16'h0000, 16'h1234, 1'b0);
        check_vec("postrst");
        pop("postrst");

        // randomized vectors against the model
        for (int v = 0; v < 15; v++) begin
            n = $urandom_range(1, IN);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 4))
                    0: rx = 16'h7FFF;
                    1: rx = 16'h8000;
                    default: rx = 16'($urandom);
                endcase
                rw = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
                send(rx, rw, (i == n - 1) && (n < IN || $urandom_range(0, 1) == 1));
            end
            check_vec("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rand_hold", out_vec, exp_vec);
            pop("rand");
        end

        // streaming throughput with in_valid and out_ready held high
        for (int i = 0; i < 12; i++) begin sx[i] = 16'($urandom); sw[i] = 16'($urandom); end
        idx = 0; nhs = 0; cyc = 0; last_hs = 0;
        out_ready = 1'b1;
        while (nhs < 3 && cyc < 200) begin
            in_valid = (idx < 12);
            if (idx < 12) begin in_x = sx[idx]; in_w = sw[idx]; end
            in_last = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                for (int k = 0; k < IN; k++) begin mx[k] = sx[nhs*IN + k]; mw[k] = sw[nhs*IN + k]; end
                mn = IN;
                check_vec("stream");
                if (nhs > 0) chk("stream_period", cyc - last_hs, PERIOD);
                last_hs = cyc;
                nhs++;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stream_done", nhs, 3);
        chk("stream_pairs", idx, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
